// File: rtl/my_id_bit_comparator.sv
// my_id_bit_comparator
//   Bit-serial passcode checker. A start request in IDLE captures Code_In and
//   compares it MSB-first, one bit per clock, against STORED_ID. Every bit is
//   always compared, so the check time does not depend on the code. The
//   result feeds the downstream pass/fail decoder. Consecutive failures are
//   counted, and entry is locked out once MAX_TRIES is reached.
//
// Ports
//   Clk                    system clock, rising edge
//   Rst                    synchronous active-high reset
//   Start_In               check request, sampled only in IDLE
//   Code_In                entered passcode, captured on an accepted start
//   ID_MissMatch_Flag_Out  sticky mismatch flag for the current/last attempt
//   LastBitFlag_Out        high once the final bit has been compared
//   Busy_Out               high while comparing (SHIFT, DONE)
//   Lockout_Out            high in LOCK; only Rst leaves LOCK
//   Fail_Count_Out         consecutive-failure count, saturating at MAX_TRIES
module my_id_bit_comparator #(
  parameter int                ID_WIDTH  = 16,
  parameter logic [ID_WIDTH-1:0] STORED_ID = 16'h6728,
  parameter int                MAX_TRIES = 3
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Start_In,
  input  logic [ID_WIDTH-1:0] Code_In,
  output logic                ID_MissMatch_Flag_Out,
  output logic                LastBitFlag_Out,
  output logic                Busy_Out,
  output logic                Lockout_Out,
  output logic [1:0]          Fail_Count_Out
);

  localparam int CNT_W = (ID_WIDTH > 2) ? $clog2(ID_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ID_WIDTH - 1);
  localparam logic [1:0]       MAX_CNT  = 2'(MAX_TRIES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    LOCK  = 2'd3
  } state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] code_sr;
  logic [ID_WIDTH-1:0] id_sr;
  logic [CNT_W-1:0]    bit_cnt;
  logic                mismatch;
  logic                last_bit;
  logic                busy;
  logic                lockout;
  logic [1:0]          fail_cnt;
  logic                mismatch_next;

  // Mismatch including the bit compared on this edge; the fail counter must
  // use this value on the final edge, not the registered one.
  always_comb begin
    mismatch_next = mismatch | (code_sr[ID_WIDTH-1] ^ id_sr[ID_WIDTH-1]);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      code_sr  <= '0;
      id_sr    <= '0;
      bit_cnt  <= '0;
      mismatch <= 1'b0;
      last_bit <= 1'b0;
      busy     <= 1'b0;
      lockout  <= 1'b0;
      fail_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start_In) begin
            code_sr  <= Code_In;
            id_sr    <= STORED_ID;
            mismatch <= 1'b0;
            last_bit <= 1'b0;
            bit_cnt  <= CNT_INIT;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          mismatch <= mismatch_next;
          code_sr  <= {code_sr[ID_WIDTH-2:0], 1'b0};
          id_sr    <= {id_sr[ID_WIDTH-2:0], 1'b0};
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else begin
            last_bit <= 1'b1;
            state    <= DONE;
            if (mismatch_next) begin
              if (fail_cnt < MAX_CNT) begin
                fail_cnt <= fail_cnt + 1'b1;
              end
            end else begin
              fail_cnt <= '0;
            end
          end
        end
        DONE: begin
          busy <= 1'b0;
          if (fail_cnt == MAX_CNT) begin
            lockout <= 1'b1;
            state   <= LOCK;
          end else begin
            state <= IDLE;
          end
        end
        LOCK: begin
          lockout <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ID_MissMatch_Flag_Out = mismatch;
  assign LastBitFlag_Out       = last_bit;
  assign Busy_Out              = busy;
  assign Lockout_Out           = lockout;
  assign Fail_Count_Out        = fail_cnt;

endmodule

// File: tb/tb_my_id_bit_comparator.sv
// Self-checking bench for my_id_bit_comparator: a table of back-to-back
// attempts with hand-computed results, plus directed multi-cycle sequences.
module tb_my_id_bit_comparator;

  logic        Clk;
  logic        Rst;
  logic        Start_In;
  logic [15:0] Code_In;
  logic        ID_MissMatch_Flag_Out;
  logic        LastBitFlag_Out;
  logic        Busy_Out;
  logic        Lockout_Out;
  logic [1:0]  Fail_Count_Out;

  int unsigned checks;
  int unsigned errors;

  my_id_bit_comparator #(
    .ID_WIDTH (16),
    .STORED_ID(16'h6728),
    .MAX_TRIES(3)
  ) dut (
    .Clk                  (Clk),
    .Rst                  (Rst),
    .Start_In             (Start_In),
    .Code_In              (Code_In),
    .ID_MissMatch_Flag_Out(ID_MissMatch_Flag_Out),
    .LastBitFlag_Out      (LastBitFlag_Out),
    .Busy_Out             (Busy_Out),
    .Lockout_Out          (Lockout_Out),
    .Fail_Count_Out       (Fail_Count_Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] code;
    logic        exp_mm;
    logic [1:0]  exp_fc;
    logic        exp_lock;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " mm"},   32'(ID_MissMatch_Flag_Out), 0);
    chk({tag, " last"}, 32'(LastBitFlag_Out), 0);
    chk({tag, " busy"}, 32'(Busy_Out), 0);
    chk({tag, " lock"}, 32'(Lockout_Out), 0);
    chk({tag, " fc"},   32'(Fail_Count_Out), 0);
  endtask

  // Full attempt: start sampled at edge 0, results after edge 16, exit after 17.
  task automatic attempt(input string tag, input logic [15:0] code,
                         input logic exp_mm, input logic [1:0] exp_fc,
                         input logic exp_lock);
    Start_In = 1'b1;
    Code_In  = code;
    step();                               // edge 0
    Start_In = 1'b0;
    Code_In  = ~code;                     // must not affect the captured code
    chk({tag, " busy@0"}, 32'(Busy_Out), 1);
    chk({tag, " last@0"}, 32'(LastBitFlag_Out), 0);
    repeat (15) step();                   // edges 1..15
    chk({tag, " last@15"}, 32'(LastBitFlag_Out), 0);
    step();                               // edge 16
    chk({tag, " last@16"}, 32'(LastBitFlag_Out), 1);
    chk({tag, " mm@16"},   32'(ID_MissMatch_Flag_Out), 32'(exp_mm));
    chk({tag, " fc@16"},   32'(Fail_Count_Out), 32'(exp_fc));
    chk({tag, " busy@16"}, 32'(Busy_Out), 1);
    step();                               // edge 17
    chk({tag, " busy@17"}, 32'(Busy_Out), 0);
    chk({tag, " lock@17"}, 32'(Lockout_Out), 32'(exp_lock));
    chk({tag, " mm@17"},   32'(ID_MissMatch_Flag_Out), 32'(exp_mm));
    chk({tag, " last@17"}, 32'(LastBitFlag_Out), 1);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    Rst      = 1'b1;
    Start_In = 1'b0;
    Code_In  = '0;

    vecs[0] = '{16'h6728, 1'b0, 2'd0, 1'b0};  // correct code
    vecs[1] = '{16'h6729, 1'b1, 2'd1, 1'b0};  // LSB wrong
    vecs[2] = '{16'h6728, 1'b0, 2'd0, 1'b0};  // match clears count
    vecs[3] = '{16'h0000, 1'b1, 2'd1, 1'b0};
    vecs[4] = '{16'hE728, 1'b1, 2'd2, 1'b0};  // MSB wrong
    vecs[5] = '{16'h6728, 1'b0, 2'd0, 1'b0};  // two failures then clear
    vecs[6] = '{16'hFFFF, 1'b1, 2'd1, 1'b0};
    vecs[7] = '{16'h0000, 1'b1, 2'd2, 1'b0};
    vecs[8] = '{16'h0000, 1'b1, 2'd3, 1'b1};  // third failure locks

    repeat (2) step();
    Rst = 1'b0;
    check_reset_vals("reset");

    for (int i = 0; i < 9; i++) begin
      attempt($sformatf("vec%0d", i), vecs[i].code, vecs[i].exp_mm,
              vecs[i].exp_fc, vecs[i].exp_lock);
      // Idle gap: flags hold in IDLE/LOCK while Start_In is low.
      step();
      chk($sformatf("vec%0d hold last", i), 32'(LastBitFlag_Out), 1);
      chk($sformatf("vec%0d hold fc", i), 32'(Fail_Count_Out), 32'(vecs[i].exp_fc));
    end

    // Locked: a fourth start is ignored.
    Start_In = 1'b1;
    Code_In  = 16'h6728;
    repeat (3) step();
    Start_In = 1'b0;
    chk("lock start busy", 32'(Busy_Out), 0);
    chk("lock start lock", 32'(Lockout_Out), 1);
    chk("lock start fc",   32'(Fail_Count_Out), 3);
    chk("lock start mm",   32'(ID_MissMatch_Flag_Out), 1);

    // Rst exits LOCK and clears everything.
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    check_reset_vals("unlock");

    // Single-bit error trace: mismatch only appears with the final bit.
    Start_In = 1'b1;
    Code_In  = 16'h6729;
    step();
    Start_In = 1'b0;
    repeat (15) begin
      step();
      chk("lsb mm pre", 32'(ID_MissMatch_Flag_Out), 0);
    end
    step();
    chk("lsb mm@16", 32'(ID_MissMatch_Flag_Out), 1);
    chk("lsb last@16", 32'(LastBitFlag_Out), 1);
    chk("lsb fc@16", 32'(Fail_Count_Out), 1);
    step();
    chk("lsb busy@17", 32'(Busy_Out), 0);

    // Busy rejection: starts at edges 5, 16, 17 ignored; accepted at 18.
    Start_In = 1'b1;
    Code_In  = 16'h6728;
    step();                               // edge 0
    Start_In = 1'b0;
    repeat (4) step();                    // edges 1..4
    Start_In = 1'b1;
    Code_In  = 16'h0000;
    step();                               // edge 5
    Start_In = 1'b0;
    repeat (10) step();                   // edges 6..15
    Start_In = 1'b1;
    step();                               // edge 16
    chk("busyrej mm@16", 32'(ID_MissMatch_Flag_Out), 0);
    chk("busyrej fc@16", 32'(Fail_Count_Out), 0);
    chk("busyrej last@16", 32'(LastBitFlag_Out), 1);
    step();                               // edge 17, DONE ignores start
    chk("busyrej busy@17", 32'(Busy_Out), 0);
    chk("busyrej last@17", 32'(LastBitFlag_Out), 1);
    step();                               // edge 18, accepted
    Start_In = 1'b0;
    chk("busyrej busy@18", 32'(Busy_Out), 1);
    chk("busyrej last@18", 32'(LastBitFlag_Out), 0);
    repeat (16) step();                   // edges 19..34: code 0000 fails
    chk("busyrej2 last", 32'(LastBitFlag_Out), 1);
    chk("busyrej2 mm", 32'(ID_MissMatch_Flag_Out), 1);
    chk("busyrej2 fc", 32'(Fail_Count_Out), 1);
    step();

    // Reset mid-shift at edge 8, then a fresh attempt completes normally.
    Start_In = 1'b1;
    Code_In  = 16'h0000;
    step();                               // edge 0
    Start_In = 1'b0;
    repeat (7) step();                    // edges 1..7
    Rst = 1'b1;
    Start_In = 1'b1;                      // Rst has priority
    step();                               // edge 8
    Rst = 1'b0;
    Start_In = 1'b0;
    check_reset_vals("midrst");
    attempt("postrst", 16'h0000, 1'b1, 2'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net: the stimulus is fixed-length, but never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
